// File: rtl/md5_stream_sequencer_if.sv
// Signal bundle between the MD5 stream sequencer, its word/digest streams
// and the pancham MD5 core. The sequencer uses the master view; the
// surrounding logic (stream source, digest sink, core) uses the slave view.
interface md5_stream_sequencer_if;
  // Message word stream into the sequencer
  logic [31:0]  s_data;
  logic         s_valid;
  logic         s_last;
  logic         s_ready;
  // Digest stream out of the sequencer
  logic [127:0] d_data;
  logic         d_valid;
  logic         d_ready;
  // Pancham core side
  logic         core_rst;
  logic [511:0] core_msg_padded;
  logic         core_msg_in_valid;
  logic [127:0] core_msg_output;
  logic         core_msg_out_valid;
  logic         core_ready;

  modport master (
    input  s_data, s_valid, s_last, d_ready,
    input  core_msg_output, core_msg_out_valid, core_ready,
    output s_ready, d_data, d_valid,
    output core_rst, core_msg_padded, core_msg_in_valid
  );

  modport slave (
    output s_data, s_valid, s_last, d_ready,
    output core_msg_output, core_msg_out_valid, core_ready,
    input  s_ready, d_data, d_valid,
    input  core_rst, core_msg_padded, core_msg_in_valid
  );
endinterface

// File: rtl/md5_stream_sequencer.sv
// Stream-to-block controller for the pancham MD5 core. Packs pre-padded
// 32-bit words into 512-bit blocks, resets the core once per message,
// launches one block at a time and hands back the 128-bit digest.
module md5_stream_sequencer #(
  parameter int TO_W  = 12,
  parameter int CNT_W = 16
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  md5_stream_sequencer_if.master bus,
  output logic                   busy,
  output logic                   err,
  output logic [CNT_W-1:0]       blocks_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RSTC,
    S_FILL,
    S_WAITR,
    S_LAUNCH,
    S_BUSY,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       idx_q, idx_d;          // word slot within the current block
  logic [511:0]     blk_q, blk_d;          // block buffer, drives the core directly
  logic             is_last_q, is_last_d;  // current block closes the message
  logic [TO_W-1:0]  to_q, to_d;            // BUSY cycles elapsed for this block
  logic [TO_W-1:0]  to_inc;
  logic [127:0]     dig_q, dig_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] done_q, done_d;
  logic             blk_complete;

  // Next-state and datapath updates for the whole controller
  always_comb begin
    // NOTE: every _d starts as its _q value so no path leaves a signal unassigned (no latches).
    state_d   = state_q;
    idx_d     = idx_q;
    blk_d     = blk_q;
    is_last_d = is_last_q;
    to_d      = to_q;
    dig_d     = dig_q;
    err_d     = err_q;
    done_d    = done_q;
    to_inc    = to_q + 1'b1;

    // The core may still show ready in the first BUSY cycle (to_q == 0), so
    // that cycle never completes a block. The final block also needs a valid digest.
    blk_complete = (state_q == S_BUSY) && (to_q != '0) && bus.core_ready &&
                   (!is_last_q || bus.core_msg_out_valid);

    unique case (state_q)
      S_IDLE: begin
        // Only look at s_valid here; the word itself is taken in FILL.
        if (bus.s_valid) state_d = S_RSTC;
      end
      S_RSTC: begin
        state_d = S_FILL;
      end
      S_FILL: begin
        if (bus.s_valid) begin
          if (bus.s_last && idx_q != 4'd15) begin
            // Message ends mid-block: drop it, flag it, never launch.
            err_d   = 1'b1;
            idx_d   = '0;
            state_d = S_IDLE;
          end else begin
            // Slot k lands at bits [511-32k -: 32]; {~k, 5'h1f} is that top bit.
            blk_d[{~idx_q, 5'h1f} -: 32] = bus.s_data;
            if (idx_q == 4'd15) begin
              idx_d     = '0;
              is_last_d = bus.s_last;
              state_d   = S_WAITR;
            end else begin
              idx_d = idx_q + 4'd1;
            end
          end
        end
      end
      S_WAITR: begin
        if (bus.core_ready) state_d = S_LAUNCH;
      end
      S_LAUNCH: begin
        to_d    = '0;
        state_d = S_BUSY;
      end
      S_BUSY: begin
        if (blk_complete) begin
          done_d = done_q + 1'b1;
          if (is_last_q) begin
            dig_d   = bus.core_msg_output;
            state_d = S_DONE;
          end else begin
            state_d = S_FILL;
          end
        end else begin
          to_d = to_inc;
          if (to_inc == '1) begin
            // Core never finished: abandon the message without a digest.
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_DONE: begin
        if (bus.d_ready) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      // NOTE: state registers take non-blocking assignments so every flop samples pre-edge values.
      state_q   <= S_IDLE;
      idx_q     <= '0;
      // NOTE: the block buffer is reset like any other register so core_msg_padded shows zeros, not stale message data.
      blk_q     <= '0;
      is_last_q <= 1'b0;
      to_q      <= '0;
      dig_q     <= '0;
      err_q     <= 1'b0;
      done_q    <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      blk_q     <= blk_d;
      is_last_q <= is_last_d;
      to_q      <= to_d;
      dig_q     <= dig_d;
      err_q     <= err_d;
      done_q    <= done_d;
    end
  end

  // Outputs decoded from state only; s_ready never depends on s_valid.
  assign bus.s_ready           = (state_q == S_FILL);
  assign bus.d_valid           = (state_q == S_DONE);
  assign bus.d_data            = dig_q;
  assign bus.core_msg_padded   = blk_q;
  assign bus.core_msg_in_valid = (state_q == S_LAUNCH);
  assign bus.core_rst          = wb_rst_i | (state_q == S_RSTC);
  assign busy                  = (state_q != S_IDLE);
  assign err                   = err_q;
  assign blocks_done           = done_q;

endmodule

// File: tb/tb_md5_stream_sequencer.sv
// Bench for md5_stream_sequencer: a behavioural pancham stand-in computes real
// MD5 compressions, and a message-level reference computes expected digests,
// pulse counts, error flag and block count for each table entry.
module tb_md5_stream_sequencer;

  localparam int TO_W  = 4;
  localparam int CNT_W = 16;
  localparam logic [127:0] MD5_IV  = 128'h67452301_efcdab89_98badcfe_10325476;
  localparam logic [127:0] ABC_DIG = 128'h900150983cd24fb0d6963f7d28e17f72;

  logic clk;
  logic wb_rst;
  logic busy, err;
  logic [CNT_W-1:0] blocks_done;

  md5_stream_sequencer_if bus ();

  md5_stream_sequencer #(.TO_W(TO_W), .CNT_W(CNT_W)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (wb_rst),
    .bus         (bus),
    .busy        (busy),
    .err         (err),
    .blocks_done (blocks_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- MD5 reference ----------------
  logic [31:0] k_tab [64];
  int s_tab [16] = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};

  function automatic logic [31:0] bswap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  // Message bytes are packed big-endian into the block (byte 0 in [511:504]).
  function automatic logic [127:0] md5_compress(input logic [127:0] h, input logic [511:0] blk);
    logic [31:0] a, b, c, d, f, m, t;
    int g, sh;
    a = h[127:96]; b = h[95:64]; c = h[63:32]; d = h[31:0];
    for (int i = 0; i < 64; i++) begin
      case (i / 16)
        0:       begin f = (b & c) | (~b & d); g = i;                end
        1:       begin f = (d & b) | (~d & c); g = (5 * i + 1) % 16; end
        2:       begin f = b ^ c ^ d;          g = (3 * i + 5) % 16; end
        default: begin f = c ^ (b | ~d);       g = (7 * i) % 16;     end
      endcase
      m  = bswap(blk[511 - 32 * g -: 32]);
      t  = f + a + k_tab[i] + m;
      sh = s_tab[(i / 16) * 4 + (i % 4)];
      a  = d;
      d  = c;
      c  = b;
      b  = b + ((t << sh) | (t >> (32 - sh)));
    end
    return {h[127:96] + a, h[95:64] + b, h[63:32] + c, h[31:0] + d};
  endfunction

  function automatic logic [127:0] to_digest(input logic [127:0] h);
    return {bswap(h[127:96]), bswap(h[95:64]), bswap(h[63:32]), bswap(h[31:0])};
  endfunction

  function automatic logic [127:0] md5_msg(input logic [31:0] w[$]);
    logic [127:0] h;
    logic [511:0] blk;
    h = MD5_IV;
    for (int b = 0; b < w.size() / 16; b++) begin
      blk = '0;
      for (int j = 0; j < 16; j++) blk = {blk[479:0], w[16 * b + j]};
      h = md5_compress(h, blk);
    end
    return to_digest(h);
  endfunction

  // ---------------- pancham core stand-in ----------------
  // Ready stays high through the first cycle after launch, then drops until
  // the compression finishes after a random latency.
  logic [127:0] core_h;
  logic [511:0] core_blk;
  int           core_cnt;
  bit           core_act;
  bit           core_stuck;

  always @(posedge clk) begin
    if (bus.core_rst) begin
      core_h                 <= MD5_IV;
      core_act               <= 1'b0;
      core_cnt               <= 0;
      bus.core_ready         <= 1'b1;
      bus.core_msg_out_valid <= 1'b0;
      bus.core_msg_output    <= '0;
    end else if (bus.core_msg_in_valid) begin
      core_blk <= bus.core_msg_padded;
      core_act <= 1'b1;
      core_cnt <= int'($urandom_range(0, 5));
    end else if (core_act) begin
      bus.core_ready <= 1'b0;
      if (core_cnt == 0) begin
        core_act <= 1'b0;
        if (!core_stuck) begin
          core_h                 <= md5_compress(core_h, core_blk);
          bus.core_msg_output    <= to_digest(md5_compress(core_h, core_blk));
          bus.core_msg_out_valid <= 1'b1;
          bus.core_ready         <= 1'b1;
        end
      end else begin
        core_cnt <= core_cnt - 1;
      end
    end
  end

  // Pulse monitors: core resets issued by the sequencer itself, and launches
  int rst_pulses = 0;
  int launches   = 0;
  always @(posedge clk) begin
    if (bus.core_rst && !wb_rst) rst_pulses <= rst_pulses + 1;
    if (bus.core_msg_in_valid)   launches   <= launches + 1;
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: no response within the cycle bound", name);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " s_ready"},     512'(bus.s_ready),           512'(0));
    check({tag, " d_valid"},     512'(bus.d_valid),           512'(0));
    check({tag, " d_data"},      512'(bus.d_data),            512'(0));
    check({tag, " busy"},        512'(busy),                  512'(0));
    check({tag, " err"},         512'(err),                   512'(0));
    check({tag, " blocks_done"}, 512'(blocks_done),           512'(0));
    check({tag, " in_valid"},    512'(bus.core_msg_in_valid), 512'(0));
    check({tag, " msg_padded"},  bus.core_msg_padded,         512'(0));
  endtask

  task automatic push_word(input logic [31:0] w, input bit last, output bit ok);
    bus.s_data  = w;
    bus.s_last  = last;
    bus.s_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (bus.s_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  // ---------------- stimulus table ----------------
  typedef enum int {K_ABC, K_A56, K_RAND} kind_e;
  typedef struct {
    kind_e kind;
    int    nblk;        // blocks in the padded message
    int    bad_at;      // word index carrying an early s_last, -1 for none
    bit    stuck;       // core never finishes the block
    bit    exp_err;     // message raises err
    bit    exp_digest;  // message delivers a digest
    int    exp_launch;  // msg_in_valid pulses
    int    exp_blk_inc; // blocks_done increment
  } vec_t;

  vec_t vecs [11];

  bit              exp_err_acc = 1'b0;
  logic [CNT_W-1:0] exp_blocks = '0;

  task automatic run_vector(input vec_t v, input int id, input int hold);
    logic [31:0]  w[$];
    logic [127:0] exp_dig;
    int           rp0, lp0, nw, viol, busy_cycles;
    bit           ok;
    string        tag;

    tag = $sformatf("v%0d", id);
    w = {};
    case (v.kind)
      K_ABC: begin
        w.push_back(32'h61626380);
        for (int i = 1; i < 14; i++) w.push_back(32'h0);
        w.push_back(32'h18000000);
        w.push_back(32'h0);
      end
      K_A56: begin
        for (int i = 0; i < 14; i++) w.push_back(32'h61616161);
        w.push_back(32'h80000000);
        w.push_back(32'h0);
        for (int i = 0; i < 14; i++) w.push_back(32'h0);
        w.push_back(32'hc0010000);
        w.push_back(32'h0);
      end
      default: begin
        for (int i = 0; i < 16 * v.nblk; i++) w.push_back($urandom);
      end
    endcase
    exp_dig    = (v.kind == K_ABC) ? ABC_DIG : md5_msg(w);
    core_stuck = v.stuck;
    rp0 = rst_pulses;
    lp0 = launches;
    nw  = (v.bad_at >= 0) ? v.bad_at + 1 : w.size();

    for (int i = 0; i < nw; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      push_word(w[i], (i == v.bad_at) || (i == w.size() - 1), ok);
      if (!ok) begin
        bound_fail({tag, " s_ready"});
        return;
      end
    end

    if (v.bad_at >= 0) begin
      @(negedge clk);
      check({tag, " busy after early last"}, 512'(busy), 512'(0));
    end else if (v.stuck) begin
      ok = 1'b0;
      for (int t = 0; t < 50; t++) begin
        @(negedge clk);
        if (bus.core_msg_in_valid) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) begin
        bound_fail({tag, " launch"});
        return;
      end
      busy_cycles = 0;
      for (int t = 0; t < 100; t++) begin
        @(negedge clk);
        if (!busy) break;
        busy_cycles++;
      end
      check({tag, " BUSY cycles before timeout"}, 512'(busy_cycles), 512'((1 << TO_W) - 1));
    end else begin
      ok = 1'b0;
      for (int t = 0; t < 400; t++) begin
        @(negedge clk);
        if (bus.d_valid) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) begin
        bound_fail({tag, " d_valid"});
        return;
      end
      check({tag, " digest"}, 512'(bus.d_data), 512'(exp_dig));
      viol = 0;
      for (int t = 0; t < hold; t++) begin
        @(negedge clk);
        if (!bus.d_valid || bus.d_data !== exp_dig || bus.s_ready) viol++;
      end
      check({tag, " hold stability"}, 512'(viol), 512'(0));
      bus.d_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.d_ready = 1'b0;
    end

    exp_err_acc = exp_err_acc | v.exp_err;
    exp_blocks  = exp_blocks + CNT_W'(v.exp_blk_inc);
    @(negedge clk);
    check({tag, " busy"},        512'(busy),             512'(0));
    check({tag, " d_valid"},     512'(bus.d_valid),      512'(0));
    check({tag, " err"},         512'(err),              512'(exp_err_acc));
    check({tag, " blocks_done"}, 512'(blocks_done),      512'(exp_blocks));
    check({tag, " launches"},    512'(launches - lp0),   512'(v.exp_launch));
    check({tag, " core_rst"},    512'(rst_pulses - rp0), 512'(1));
    if (v.exp_digest) check({tag, " d_data held"}, 512'(bus.d_data), 512'(exp_dig));
    core_stuck = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit ok;
    vec_t abc_v;

    for (int i = 0; i < 64; i++) begin
      real s;
      s = $sin(real'(i + 1));
      if (s < 0.0) s = -s;
      k_tab[i] = 32'(longint'($floor(s * 4294967296.0)));
    end

    core_stuck  = 1'b0;
    wb_rst      = 1'b1;
    bus.s_data  = '0;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    bus.d_ready = 1'b0;

    vecs[0]  = '{K_ABC,  1, -1, 1'b0, 1'b0, 1'b1, 1, 1};
    vecs[1]  = '{K_A56,  2, -1, 1'b0, 1'b0, 1'b1, 2, 2};
    vecs[2]  = '{K_RAND, 1, -1, 1'b0, 1'b0, 1'b1, 1, 1};
    vecs[3]  = '{K_RAND, 3, -1, 1'b0, 1'b0, 1'b1, 3, 3};
    vecs[4]  = '{K_RAND, 1,  5, 1'b0, 1'b1, 1'b0, 0, 0};
    vecs[5]  = '{K_ABC,  1, -1, 1'b0, 1'b0, 1'b1, 1, 1};
    vecs[6]  = '{K_RAND, 1,  0, 1'b0, 1'b1, 1'b0, 0, 0};
    vecs[7]  = '{K_RAND, 2, -1, 1'b0, 1'b0, 1'b1, 2, 2};
    vecs[8]  = '{K_RAND, 1, 14, 1'b0, 1'b1, 1'b0, 0, 0};
    vecs[9]  = '{K_RAND, 1, -1, 1'b1, 1'b1, 1'b0, 1, 0};
    vecs[10] = '{K_RAND, 1, -1, 1'b0, 1'b0, 1'b1, 1, 1};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    check("reset core_rst", 512'(bus.core_rst), 512'(1));
    @(posedge clk);
    #1;
    wb_rst = 1'b0;
    @(negedge clk);
    check("idle core_rst", 512'(bus.core_rst), 512'(0));

    // First vector holds d_ready low for 50 cycles while the digest waits.
    for (int i = 0; i < 11; i++) run_vector(vecs[i], i, (i == 0) ? 50 : int'($urandom_range(0, 3)));

    // Reset in the middle of filling a block (word 7 on the bus).
    abc_v = vecs[0];
    push_word(32'h61626380, 1'b0, ok);
    for (int i = 1; i < 7 && ok; i++) push_word(32'h0, 1'b0, ok);
    if (!ok) bound_fail("midfill s_ready");
    bus.s_data  = 32'h0;
    bus.s_valid = 1'b1;
    wb_rst      = 1'b1;
    @(negedge clk);
    check("midfill core_rst during reset", 512'(bus.core_rst), 512'(1));
    @(posedge clk);
    #1;
    wb_rst      = 1'b0;
    bus.s_valid = 1'b0;
    @(negedge clk);
    check_reset_outputs("after midfill reset");
    check("after midfill core_rst", 512'(bus.core_rst), 512'(0));
    exp_err_acc = 1'b0;
    exp_blocks  = '0;
    run_vector(abc_v, 11, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
